// File: rtl/axi_ram_burst.sv
// axi_ram_burst: AXI4 burst slave in front of a single-clock dual-port RAM.
// The write path (AW/W/B) and the read path (AR/R) are independent FSMs
// that share only the memory array.
//
// Ports:
//   s_aclk, s_areset      clock, asynchronous active-high reset
//   s_axi_aw*             write address channel (id, addr, len, size, burst)
//   s_axi_w*              write data channel (data, strb, last)
//   s_axi_b*              write response channel (id, resp)
//   s_axi_ar*             read address channel (id, addr, len, size, burst)
//   s_axi_r*              read data channel (id, data, resp, last)
//
// Build option: define AXI_RAM_WRAP_EN to support WRAP bursts; without it
// WRAP is treated like the reserved burst type (SLVERR, no writes, zero data).
// Beats are always full width: awsize/arsize and sub-word address bits are
// ignored.
module axi_ram_burst #(
  parameter int G_DATAWIDTH = 32,
  parameter int G_MEMDEPTH  = 1024,
  parameter int G_ID_WIDTH  = 4,
  parameter int G_STRBWIDTH = G_DATAWIDTH / 8,
  parameter int G_ADDRWIDTH = $clog2(G_MEMDEPTH * G_STRBWIDTH)
) (
  input  logic                   s_aclk,
  input  logic                   s_areset,
  input  logic [G_ID_WIDTH-1:0]  s_axi_awid,
  input  logic [G_ADDRWIDTH-1:0] s_axi_awaddr,
  input  logic [7:0]             s_axi_awlen,
  input  logic [2:0]             s_axi_awsize,
  input  logic [1:0]             s_axi_awburst,
  input  logic                   s_axi_awvalid,
  output logic                   s_axi_awready,
  input  logic [G_DATAWIDTH-1:0] s_axi_wdata,
  input  logic [G_STRBWIDTH-1:0] s_axi_wstrb,
  input  logic                   s_axi_wlast,
  input  logic                   s_axi_wvalid,
  output logic                   s_axi_wready,
  output logic [G_ID_WIDTH-1:0]  s_axi_bid,
  output logic [1:0]             s_axi_bresp,
  output logic                   s_axi_bvalid,
  input  logic                   s_axi_bready,
  input  logic [G_ID_WIDTH-1:0]  s_axi_arid,
  input  logic [G_ADDRWIDTH-1:0] s_axi_araddr,
  input  logic [7:0]             s_axi_arlen,
  input  logic [2:0]             s_axi_arsize,
  input  logic [1:0]             s_axi_arburst,
  input  logic                   s_axi_arvalid,
  output logic                   s_axi_arready,
  output logic [G_ID_WIDTH-1:0]  s_axi_rid,
  output logic [G_DATAWIDTH-1:0] s_axi_rdata,
  output logic [1:0]             s_axi_rresp,
  output logic                   s_axi_rlast,
  output logic                   s_axi_rvalid,
  input  logic                   s_axi_rready
);

  localparam int IW = $clog2(G_MEMDEPTH);
  localparam int BW = $clog2(G_STRBWIDTH);
`ifdef AXI_RAM_WRAP_EN
  localparam bit WRAP_EN = 1'b1;
`else
  localparam bit WRAP_EN = 1'b0;
`endif

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
  typedef enum logic       {R_IDLE, R_BURST}        r_state_t;

  function automatic logic burst_bad(input logic [1:0] burst, input logic [7:0] len);
    case (burst)
      2'b00, 2'b01: return 1'b0;
      2'b10:        return !WRAP_EN ||
                           !(len == 8'd1 || len == 8'd3 || len == 8'd7 || len == 8'd15);
      default:      return 1'b1;
    endcase
  endfunction

  // WRAP keeps the upper index bits and counts only within the len+1 block.
  function automatic logic [IW-1:0] next_idx(input logic [IW-1:0] idx,
                                             input logic [7:0] len,
                                             input logic [1:0] burst);
    logic [IW-1:0] mask;
    mask = IW'(len);
    case (burst)
      2'b00:   return idx;
      2'b10:   return (idx & ~mask) | ((idx + IW'(1)) & mask);
      default: return idx + IW'(1);
    endcase
  endfunction

  logic [G_DATAWIDTH-1:0] mem [G_MEMDEPTH];
  logic [G_DATAWIDTH-1:0] mem_q;

  // ---------------- write path ----------------
  w_state_t      w_state, w_next;
  logic [IW-1:0] w_idx;
  logic [7:0]    w_len, w_cnt;
  logic [1:0]    w_burst;
  logic          w_bad;
  logic          aw_fire, w_fire, b_fire, w_at_len, w_final, mem_we;

  assign aw_fire  = s_axi_awvalid & s_axi_awready;
  assign w_fire   = s_axi_wvalid & s_axi_wready;
  assign b_fire   = s_axi_bvalid & s_axi_bready;
  assign w_at_len = (w_cnt == w_len);
  assign w_final  = s_axi_wlast | w_at_len;
  assign mem_we   = w_fire & ~w_bad;

  always_comb begin
    w_next = w_state;
    case (w_state)
      W_IDLE:  if (aw_fire) w_next = W_DATA;
      W_DATA:  if (w_fire && w_final) w_next = W_RESP;
      W_RESP:  if (b_fire) w_next = W_IDLE;
      default: w_next = W_IDLE;
    endcase
  end

  // Handshake outputs are registered from the next state so they stay low
  // while reset is held and rise on the first clock after release.
  always_ff @(posedge s_aclk or posedge s_areset) begin
    if (s_areset) begin
      w_state       <= W_IDLE;
      s_axi_awready <= 1'b0;
      s_axi_wready  <= 1'b0;
      s_axi_bvalid  <= 1'b0;
      s_axi_bid     <= '0;
      s_axi_bresp   <= '0;
      w_idx         <= '0;
      w_len         <= '0;
      w_cnt         <= '0;
      w_burst       <= '0;
      w_bad         <= 1'b0;
    end else begin
      w_state       <= w_next;
      s_axi_awready <= (w_next == W_IDLE);
      s_axi_wready  <= (w_next == W_DATA);
      s_axi_bvalid  <= (w_next == W_RESP);
      if (aw_fire) begin
        s_axi_bid <= s_axi_awid;
        w_idx     <= s_axi_awaddr[G_ADDRWIDTH-1:BW];
        w_len     <= s_axi_awlen;
        w_cnt     <= '0;
        w_burst   <= s_axi_awburst;
        w_bad     <= burst_bad(s_axi_awburst, s_axi_awlen);
      end
      if (w_fire) begin
        w_idx <= next_idx(w_idx, w_len, w_burst);
        w_cnt <= w_cnt + 8'd1;
        // Early wlast or a missing wlast on the final beat is a protocol error.
        if (w_final)
          s_axi_bresp <= (w_bad || (s_axi_wlast != w_at_len)) ? 2'b10 : 2'b00;
      end
    end
  end

  // ---------------- read path ----------------
  r_state_t               r_state, r_next;
  logic [IW-1:0]          r_idx;
  logic [7:0]             r_len;
  logic [1:0]             r_burst;
  logic                   r_bad;
  logic [8:0]             r_rem;
  logic                   inf_valid, inf_last;
  logic [G_DATAWIDTH-1:0] buf_data [2];
  logic [1:0]             buf_last;
  logic                   rd_ptr, wr_ptr;
  logic [1:0]             occ;
  logic [2:0]             fill_after;
  logic                   ar_fire, r_pop, r_issue;

  assign ar_fire      = s_axi_arvalid & s_axi_arready;
  assign r_pop        = s_axi_rvalid & s_axi_rready;
  assign s_axi_rvalid = (occ != 2'd0);
  assign s_axi_rdata  = buf_data[rd_ptr];
  assign s_axi_rlast  = s_axi_rvalid & buf_last[rd_ptr];
  // A read may be issued only if the beat in flight plus buffered beats,
  // after this cycle's pop, leave room in the 2-entry skid buffer.
  assign fill_after   = 3'(occ) + 3'(inf_valid) - 3'(r_pop);
  assign r_issue      = (r_state == R_BURST) && (r_rem != 9'd0) && (fill_after < 3'd2);

  always_comb begin
    r_next = r_state;
    case (r_state)
      R_IDLE:  if (ar_fire) r_next = R_BURST;
      R_BURST: if (r_pop && s_axi_rlast) r_next = R_IDLE;
      default: r_next = R_IDLE;
    endcase
  end

  always_ff @(posedge s_aclk or posedge s_areset) begin
    if (s_areset) begin
      r_state       <= R_IDLE;
      s_axi_arready <= 1'b0;
      s_axi_rid     <= '0;
      s_axi_rresp   <= '0;
      r_idx         <= '0;
      r_len         <= '0;
      r_burst       <= '0;
      r_bad         <= 1'b0;
      r_rem         <= '0;
      inf_valid     <= 1'b0;
      inf_last      <= 1'b0;
      buf_data[0]   <= '0;
      buf_data[1]   <= '0;
      buf_last      <= '0;
      rd_ptr        <= 1'b0;
      wr_ptr        <= 1'b0;
      occ           <= '0;
    end else begin
      r_state       <= r_next;
      s_axi_arready <= (r_next == R_IDLE);
      if (ar_fire) begin
        s_axi_rid   <= s_axi_arid;
        s_axi_rresp <= burst_bad(s_axi_arburst, s_axi_arlen) ? 2'b10 : 2'b00;
        r_idx       <= s_axi_araddr[G_ADDRWIDTH-1:BW];
        r_len       <= s_axi_arlen;
        r_burst     <= s_axi_arburst;
        r_bad       <= burst_bad(s_axi_arburst, s_axi_arlen);
        r_rem       <= 9'(s_axi_arlen) + 9'd1;
      end
      if (r_issue) begin
        r_idx <= next_idx(r_idx, r_len, r_burst);
        r_rem <= r_rem - 9'd1;
      end
      inf_valid <= r_issue;
      inf_last  <= r_issue && (r_rem == 9'd1);
      if (inf_valid) begin
        buf_data[wr_ptr] <= r_bad ? '0 : mem_q;
        buf_last[wr_ptr] <= inf_last;
        wr_ptr           <= ~wr_ptr;
      end
      if (r_pop) rd_ptr <= ~rd_ptr;
      occ <= occ + 2'(inf_valid) - 2'(r_pop);
    end
  end

  // Read and write share one clock edge: a same-word read sees the old data.
  always_ff @(posedge s_aclk) begin
    if (mem_we)
      for (int unsigned i = 0; i < G_STRBWIDTH; i++)
        if (s_axi_wstrb[i]) mem[w_idx][8*i +: 8] <= s_axi_wdata[8*i +: 8];
    if (r_issue) mem_q <= mem[r_idx];
  end

  logic unused_ok;
  assign unused_ok = ^{s_axi_awsize, s_axi_arsize,
                       s_axi_awaddr[BW-1:0], s_axi_araddr[BW-1:0]};

endmodule

// File: tb/tb_axi_ram_burst.sv
`timescale 1ns/1ps
module tb_axi_ram_burst;
  localparam int DW    = 32;
  localparam int DEPTH = 1024;
  localparam int IDW   = 4;
  localparam int SW    = DW / 8;
  localparam int AW    = $clog2(DEPTH * SW);
`ifdef AXI_RAM_WRAP_EN
  localparam bit WRAP_EN = 1'b1;
`else
  localparam bit WRAP_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [IDW-1:0] awid = '0, arid = '0, bid, rid;
  logic [AW-1:0]  awaddr = '0, araddr = '0;
  logic [7:0]     awlen = '0, arlen = '0;
  logic [2:0]     awsize = '0, arsize = '0;
  logic [1:0]     awburst = '0, arburst = '0, bresp, rresp;
  logic           awvalid = 1'b0, awready, wlast = 1'b0, wvalid = 1'b0, wready;
  logic           bvalid, bready = 1'b0, arvalid = 1'b0, arready;
  logic           rlast, rvalid, rready = 1'b0;
  logic [DW-1:0]  wdata = '0, rdata;
  logic [SW-1:0]  wstrb = '0;

  always #5 clk = ~clk;

  axi_ram_burst #(.G_DATAWIDTH(DW), .G_MEMDEPTH(DEPTH), .G_ID_WIDTH(IDW)) dut (
    .s_aclk(clk), .s_areset(rst),
    .s_axi_awid(awid), .s_axi_awaddr(awaddr), .s_axi_awlen(awlen), .s_axi_awsize(awsize),
    .s_axi_awburst(awburst), .s_axi_awvalid(awvalid), .s_axi_awready(awready),
    .s_axi_wdata(wdata), .s_axi_wstrb(wstrb), .s_axi_wlast(wlast), .s_axi_wvalid(wvalid),
    .s_axi_wready(wready),
    .s_axi_bid(bid), .s_axi_bresp(bresp), .s_axi_bvalid(bvalid), .s_axi_bready(bready),
    .s_axi_arid(arid), .s_axi_araddr(araddr), .s_axi_arlen(arlen), .s_axi_arsize(arsize),
    .s_axi_arburst(arburst), .s_axi_arvalid(arvalid), .s_axi_arready(arready),
    .s_axi_rid(rid), .s_axi_rdata(rdata), .s_axi_rresp(rresp), .s_axi_rlast(rlast),
    .s_axi_rvalid(rvalid), .s_axi_rready(rready)
  );

  int checks = 0;
  int errors = 0;
  logic [DW-1:0] ref_mem  [DEPTH];
  logic [DW-1:0] snap_mem [DEPTH];
  logic [DW-1:0] wq[$];
  logic [SW-1:0] sq[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: burst legality and the word touched by beat i.
  function automatic bit bad_burst(input logic [1:0] b, input int len);
    if (b == 2'b00 || b == 2'b01) return 1'b0;
    if (b == 2'b11) return 1'b1;
    return !WRAP_EN || !(len == 1 || len == 3 || len == 7 || len == 15);
  endfunction

  function automatic int word_at(input int base, input int len, input logic [1:0] b, input int i);
    int n, blk;
    n = len + 1;
    case (b)
      2'b00:   return base;
      2'b10:   begin blk = (base / n) * n; return blk + ((base - blk + i) % n); end
      default: return (base + i) % DEPTH;
    endcase
  endfunction

  task automatic wait_ready(input int ch, output bit hs, output int cyc);
    cyc = 0; hs = 1'b0;
    while (!hs && cyc < 100) begin
      @(negedge clk);
      case (ch)
        0:       hs = awready;
        1:       hs = wready;
        default: hs = arready;
      endcase
      @(posedge clk);
      cyc++;
    end
  endtask

  // Sends every beat queued in wq/sq; wlast on the final one is last_flag.
  task automatic do_write(input logic [IDW-1:0] id, input int addr, input int len,
                          input logic [1:0] b, input bit last_flag, output int wcyc);
    int n, base, cyc, hold, w;
    bit bad, exp_err, hs, aw_hi;
    logic [IDW-1:0] got_id;
    logic [1:0] got_resp;
    n = wq.size(); base = addr / SW; bad = bad_burst(b, len);
    exp_err = bad || (n != len + 1) || !last_flag;
    got_id = '0; got_resp = '0; wcyc = 0;
    awid = id; awaddr = AW'(addr); awlen = 8'(len); awsize = 3'd2; awburst = b; awvalid = 1'b1;
    wait_ready(0, hs, cyc);
    check("aw_handshake", hs, 1);
    #1 awvalid = 1'b0;
    for (int i = 0; i < n; i++) begin
      wdata = wq[i]; wstrb = sq[i]; wlast = (i == n - 1) ? last_flag : 1'b0; wvalid = 1'b1;
      wait_ready(1, hs, cyc);
      wcyc += cyc;
      if (!hs) begin check("w_handshake", hs, 1); break; end
      if (!bad) begin
        w = word_at(base, len, b, i);
        for (int k = 0; k < SW; k++)
          if (sq[i][k]) ref_mem[w][8*k +: 8] = wq[i][8*k +: 8];
      end
      #1;
    end
    wvalid = 1'b0; wlast = 1'b0;
    hold = $urandom_range(0, 2); cyc = 0; hs = 1'b0; aw_hi = 1'b0;
    while (!hs && cyc < 200) begin
      if (cyc >= hold) bready = 1'b1;
      @(negedge clk);
      if (bvalid && awready) aw_hi = 1'b1;
      hs = bvalid & bready;
      if (hs) begin got_id = bid; got_resp = bresp; end
      @(posedge clk); cyc++; #1;
    end
    bready = 1'b0;
    check("b_handshake", hs, 1);
    check("b_id", got_id, id);
    check("b_resp", got_resp, exp_err ? 2'b10 : 2'b00);
    check("aw_low_in_resp", aw_hi, 0);
    wq.delete(); sq.delete();
  endtask

  // mode 0: rready held high, 1: toggled every cycle, 2: random.
  task automatic do_read(input logic [IDW-1:0] id, input int addr, input int len,
                         input logic [1:0] b, input int mode, input bit from_snap,
                         output int lat, output int gaps);
    int base, beat, cyc, w;
    bit bad, hs, held, held_l;
    logic [DW-1:0] held_d, exp_d;
    base = addr / SW; bad = bad_burst(b, len);
    beat = 0; held = 1'b0; held_l = 1'b0; held_d = '0; lat = -1; gaps = 0;
    arid = id; araddr = AW'(addr); arlen = 8'(len); arsize = 3'd2; arburst = b; arvalid = 1'b1;
    wait_ready(2, hs, cyc);
    check("ar_handshake", hs, 1);
    #1 arvalid = 1'b0;
    rready = (mode == 2) ? 1'($urandom_range(0, 1)) : 1'b1;
    cyc = 0;
    while (hs && beat <= len && cyc < 4000) begin
      @(negedge clk);
      if (held) begin
        check("r_stall_valid", rvalid, 1);
        check("r_stall_data", rdata, held_d);
        check("r_stall_last", rlast, held_l);
      end
      if (rvalid) begin
        if (lat < 0) lat = cyc;
        if (rready) begin
          w = word_at(base, len, b, beat);
          exp_d = bad ? '0 : (from_snap ? snap_mem[w] : ref_mem[w]);
          check("r_data", rdata, exp_d);
          check("r_last", rlast, beat == len);
          check("r_resp", rresp, bad ? 2'b10 : 2'b00);
          check("r_id", rid, id);
          beat++; held = 1'b0;
        end else begin
          held = 1'b1; held_d = rdata; held_l = rlast;
        end
      end else if (lat >= 0) gaps++;
      @(posedge clk); cyc++;
      #1;
      case (mode)
        1:       rready = ~rready;
        2:       rready = 1'($urandom_range(0, 1));
        default: rready = 1'b1;
      endcase
    end
    check("r_beats", beat, len + 1);
    rready = 1'b0;
    @(negedge clk);
    check("r_no_extra", rvalid, 0);
    check("r_arready_back", arready, 1);
    @(posedge clk); #1;
  endtask

  task automatic check_reset_outputs();
    check("rst_awready", awready, 0); check("rst_wready", wready, 0);
    check("rst_bvalid", bvalid, 0);   check("rst_arready", arready, 0);
    check("rst_rvalid", rvalid, 0);   check("rst_rlast", rlast, 0);
    check("rst_bid", bid, 0);         check("rst_rid", rid, 0);
    check("rst_bresp", bresp, 0);     check("rst_rresp", rresp, 0);
    check("rst_rdata", rdata, 0);
  endtask

  task automatic release_reset();
    @(negedge clk); rst = 1'b0;
    @(posedge clk); @(negedge clk);
    check("post_rst_awready", awready, 1);
    check("post_rst_arready", arready, 1);
    @(posedge clk); #1;
  endtask

  int lat, gaps, wc, cyc, len, n, addr;
  bit hs;
  logic [1:0] b;

  initial begin
    #10000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs();
    release_reset();

    // Fill the whole memory so the model is fully defined.
    for (int blk = 0; blk < DEPTH / 256; blk++) begin
      for (int i = 0; i < 256; i++) begin wq.push_back($urandom); sq.push_back('1); end
      do_write(4'(blk), blk * 256 * SW, 255, 2'b01, 1'b1, wc);
    end

    // INCR write 1..4 at 0x40 and read back.
    for (int i = 1; i <= 4; i++) begin wq.push_back(DW'(i)); sq.push_back('1); end
    do_write(4'h3, 'h40, 3, 2'b01, 1'b1, wc);
    do_read(4'h3, 'h40, 3, 2'b01, 0, 1'b0, lat, gaps);

    // Byte-lane merge on one word.
    wq.push_back(32'hAABBCCDD); sq.push_back(4'b1111);
    do_write(4'h1, 'h80, 0, 2'b01, 1'b1, wc);
    wq.push_back(32'h11223344); sq.push_back(4'b0101);
    do_write(4'h2, 'h80, 0, 2'b01, 1'b1, wc);
    check("strb_merge_model", ref_mem['h80 / SW], 32'hAA22CC44);
    do_read(4'h2, 'h80, 0, 2'b01, 0, 1'b0, lat, gaps);

    // WRAP read from 0x38 with distinct words in the block.
    for (int i = 0; i < 4; i++) begin wq.push_back(32'h3000 + DW'(i)); sq.push_back('1); end
    do_write(4'h4, 'h30, 3, 2'b01, 1'b1, wc);
    do_read(4'h4, 'h38, 3, 2'b10, 0, 1'b0, lat, gaps);

    // 16-beat read with rready toggling.
    do_read(4'h6, 'h100, 15, 2'b01, 1, 1'b0, lat, gaps);

    // Concurrent disjoint write and read at full rate.
    for (int i = 0; i < 8; i++) begin wq.push_back($urandom); sq.push_back('1); end
    fork
      do_write(4'h7, 'h400, 7, 2'b01, 1'b1, wc);
      do_read(4'h8, 'h800, 7, 2'b01, 0, 1'b0, lat, gaps);
    join
    check("w_full_rate_cycles", wc, 8);
    check("r_full_rate_gaps", gaps, 0);
    check("r_first_latency_le2", lat <= 2, 1);

    // Same words written and read in lockstep: reads return the old data.
    for (int i = 0; i < DEPTH; i++) snap_mem[i] = ref_mem[i];
    for (int i = 0; i < 8; i++) begin wq.push_back($urandom); sq.push_back('1); end
    fork
      do_write(4'h9, 'h500, 7, 2'b01, 1'b1, wc);
      do_read(4'hA, 'h500, 7, 2'b01, 0, 1'b1, lat, gaps);
    join
    do_read(4'hB, 'h500, 7, 2'b01, 2, 1'b0, lat, gaps);

    // Protocol errors: early wlast, missing wlast, reserved burst.
    for (int i = 0; i < 2; i++) begin wq.push_back($urandom); sq.push_back('1); end
    do_write(4'hC, 'h600, 5, 2'b01, 1'b1, wc);
    for (int i = 0; i < 2; i++) begin wq.push_back($urandom); sq.push_back('1); end
    do_write(4'hD, 'h640, 1, 2'b01, 1'b0, wc);
    for (int i = 0; i < 4; i++) begin wq.push_back($urandom); sq.push_back('1); end
    do_write(4'hE, 'h680, 3, 2'b11, 1'b1, wc);
    do_read(4'hE, 'h600, 7, 2'b01, 0, 1'b0, lat, gaps);
    do_read(4'hE, 'h680, 3, 2'b01, 0, 1'b0, lat, gaps);
    do_read(4'hF, 'h680, 3, 2'b11, 0, 1'b0, lat, gaps);

    // Reset during an 8-beat write: two beats land, the rest is aborted.
    awid = 4'h5; awaddr = AW'('h200); awlen = 8'd7; awsize = 3'd2; awburst = 2'b01; awvalid = 1'b1;
    wait_ready(0, hs, cyc);
    check("abort_aw_handshake", hs, 1);
    #1 awvalid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      wdata = $urandom; wstrb = '1; wlast = 1'b0; wvalid = 1'b1;
      wait_ready(1, hs, cyc);
      check("abort_w_handshake", hs, 1);
      ref_mem['h200 / SW + i] = wdata;
      #1;
    end
    wdata = $urandom; wvalid = 1'b1;
    #2 rst = 1'b1;
    @(negedge clk);
    check_reset_outputs();
    wvalid = 1'b0;
    release_reset();
    for (int i = 0; i < 4; i++) begin wq.push_back($urandom); sq.push_back('1); end
    do_write(4'h1, 'h300, 3, 2'b01, 1'b1, wc);
    do_read(4'h1, 'h300, 3, 2'b01, 0, 1'b0, lat, gaps);
    do_read(4'h2, 'h200, 2, 2'b01, 0, 1'b0, lat, gaps);

    // Randomized traffic.
    for (int it = 0; it < 40; it++) begin
      b = 2'($urandom_range(0, 3));
      len = (b == 2'b10 && $urandom_range(0, 3) != 0) ? (2 << $urandom_range(0, 3)) - 1
                                                     : $urandom_range(0, 15);
      addr = $urandom_range(0, DEPTH * SW - 1);
      n = len + 1;
      case ($urandom_range(0, 7))
        0: if (len > 0) n = $urandom_range(1, len);
        default: ;
      endcase
      for (int i = 0; i < n; i++) begin wq.push_back($urandom); sq.push_back(SW'($urandom)); end
      do_write(4'($urandom), addr, len, b, ($urandom_range(0, 7) != 0) || (n != len + 1), wc);
      do_read(4'($urandom), addr, len, b, $urandom_range(0, 2), 1'b0, lat, gaps);
      do_read(4'($urandom), $urandom_range(0, DEPTH * SW - 1), $urandom_range(0, 15),
              2'b01, $urandom_range(0, 2), 1'b0, lat, gaps);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
